// File: rtl/apu_pkg.sv
// Shared constants and encodings for the APU frame sequencer ($4017).
package apu_pkg;

  // Default CPU-cycle positions of the sequencer steps
  localparam int CNT_W_DEF    = 16;
  localparam int STEP1_DEF    = 7457;
  localparam int STEP2_DEF    = 14913;
  localparam int STEP3_DEF    = 22371;
  localparam int STEP4_DEF    = 29829;
  localparam int STEP5_DEF    = 37281;
  localparam int WR_DELAY_DEF = 3;

  // Sequencer mode as written in $4017 bit 7
  localparam logic MODE_4STEP = 1'b0;
  localparam logic MODE_5STEP = 1'b1;

  // Write-handling FSM: RUN = no write pending, PEND = waiting to apply a write
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } seq_state_e;

endpackage

// File: rtl/apu_wr_delay.sv
// Write-to-apply delay for $4017: loads WR_DELAY on a write, counts down on
// each CPU cycle and produces a one-clk apply pulse on the CPU cycle where
// the count reaches its last step. A new write restarts the count.
module apu_wr_delay #(
  parameter int WR_DELAY = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cpu_ce,
  input  logic wr_en,
  output logic apply
);

  localparam logic [2:0] DELAY_LOAD = WR_DELAY[2:0];

  logic [2:0] delay_q;
  logic [2:0] delay_d;

  // A write in the same clk as the final count wins: the earlier write is dropped
  assign apply = cpu_ce && !wr_en && (delay_q == 3'd1);

  // Next delay value: reload on write, otherwise count down on CPU cycles
  always_comb begin
    delay_d = delay_q;
    if (wr_en) begin
      delay_d = DELAY_LOAD;
    end else if (cpu_ce && (delay_q != 3'd0)) begin
      delay_d = delay_q - 3'd1;
    end
  end

  // Delay counter register, cleared by reset so nothing stays pending
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      delay_q <= 3'd0;
    end else begin
      delay_q <= delay_d;
    end
  end

endmodule

// File: rtl/apu_frame_sequencer.sv
// APU frame counter ($4017): counts CPU cycles, emits one-clk quarter/half
// frame strobes, raises the frame IRQ and applies $4017 writes after a delay.
// Build option: define FRAME_IRQ_EN to include the frame IRQ logic; without
// it irq is tied low and wr_data[6] / status_rd are ignored.
module apu_frame_sequencer
  import apu_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int STEP1    = STEP1_DEF,
  parameter int STEP2    = STEP2_DEF,
  parameter int STEP3    = STEP3_DEF,
  parameter int STEP4    = STEP4_DEF,
  parameter int STEP5    = STEP5_DEF,
  parameter int WR_DELAY = WR_DELAY_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_ce,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       qframe,
  output logic       hframe,
  output logic       irq,
  output logic       mode
);

  localparam logic [CNT_W-1:0] S1 = STEP1[CNT_W-1:0];
  localparam logic [CNT_W-1:0] S2 = STEP2[CNT_W-1:0];
  localparam logic [CNT_W-1:0] S3 = STEP3[CNT_W-1:0];
  localparam logic [CNT_W-1:0] S4 = STEP4[CNT_W-1:0];
  localparam logic [CNT_W-1:0] S5 = STEP5[CNT_W-1:0];

  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             mode_q, mode_d;
  logic             pend_mode_q, pend_mode_d;
  logic             qframe_q, qframe_d;
  logic             hframe_q, hframe_d;
  seq_state_e       state_q, state_d;

  logic [CNT_W-1:0] wrap_pt;
  logic             apply;
  logic             apply_ok;
  logic             unused_wr_bits;

  apu_wr_delay #(
    .WR_DELAY (WR_DELAY)
  ) u_wr_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .cpu_ce (cpu_ce),
    .wr_en  (wr_en),
    .apply  (apply)
  );

  assign apply_ok = apply && (state_q == ST_PEND);
  assign wrap_pt  = (mode_q == MODE_5STEP) ? S5 : S4;

  // Counter, step decode and write-state sequencing
  always_comb begin
    cyc_d       = cyc_q;
    mode_d      = mode_q;
    pend_mode_d = pend_mode_q;
    state_d     = state_q;
    qframe_d    = 1'b0;
    hframe_d    = 1'b0;

    if (cpu_ce) begin
      if ((cyc_q == S1) || (cyc_q == S3)) begin
        qframe_d = 1'b1;
      end
      if (cyc_q == S2) begin
        qframe_d = 1'b1;
        hframe_d = 1'b1;
      end
      if ((mode_q == MODE_4STEP) && (cyc_q == S4)) begin
        qframe_d = 1'b1;
        hframe_d = 1'b1;
      end
      if ((mode_q == MODE_5STEP) && (cyc_q == S5)) begin
        qframe_d = 1'b1;
        hframe_d = 1'b1;
      end
      cyc_d = (cyc_q == wrap_pt) ? '0 : cyc_q + 1'b1;
    end

    // Applying a write restarts the frame; 5-step mode clocks q+h at once
    if (apply_ok) begin
      cyc_d   = '0;
      mode_d  = pend_mode_q;
      state_d = ST_RUN;
      if (pend_mode_q == MODE_5STEP) begin
        qframe_d = 1'b1;
        hframe_d = 1'b1;
      end
    end

    if (wr_en) begin
      pend_mode_d = wr_data[7];
      state_d     = ST_PEND;
    end
  end

  // Sequencer state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc_q       <= '0;
      mode_q      <= MODE_4STEP;
      pend_mode_q <= MODE_4STEP;
      state_q     <= ST_RUN;
      qframe_q    <= 1'b0;
      hframe_q    <= 1'b0;
    end else begin
      cyc_q       <= cyc_d;
      mode_q      <= mode_d;
      pend_mode_q <= pend_mode_d;
      state_q     <= state_d;
      qframe_q    <= qframe_d;
      hframe_q    <= hframe_d;
    end
  end

  assign qframe = qframe_q;
  assign hframe = hframe_q;
  assign mode   = mode_q;

`ifdef FRAME_IRQ_EN
  logic inhibit_q, inhibit_d;
  logic irq_q, irq_d;
  logic irq_set;

  // IRQ is raised only by the 4-step final step, never when an applied
  // 5-step write restarts the frame on that same edge
  assign irq_set = cpu_ce && (mode_q == MODE_4STEP) && (cyc_q == S4) &&
                   !inhibit_q && !(apply_ok && (pend_mode_q == MODE_5STEP));

  // Inhibit latch and IRQ level: a set beats any clear in the same clk
  always_comb begin
    inhibit_d = inhibit_q;
    irq_d     = irq_q;
    if (wr_en) begin
      inhibit_d = wr_data[6];
    end
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (status_rd || (wr_en && wr_data[6])) begin
      irq_d = 1'b0;
    end
  end

  // IRQ state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inhibit_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      inhibit_q <= inhibit_d;
      irq_q     <= irq_d;
    end
  end

  assign irq            = irq_q;
  assign unused_wr_bits = ^wr_data[5:0];
`else
  assign irq            = 1'b0;
  assign unused_wr_bits = ^{wr_data[6:0], status_rd};
`endif

endmodule

// File: doc/apu_frame_sequencer.md
Name: apu_frame_sequencer

Overview:
Frame counter for the APU, equivalent to register $4017. It counts CPU cycles and emits one-clock quarter-frame and half-frame strobes. These strobes drive the envelope, length-counter and sweep units of the noise, pulse and triangle channels. It also raises the frame IRQ and applies $4017 writes after the hardware reset delay.

Parameters:
CNT_W, 16, width of CPU-cycle counter
STEP1, 7457, cycle of step 1 (quarter)
STEP2, 14913, cycle of step 2 (quarter+half)
STEP3, 22371, cycle of step 3 (quarter)
STEP4, 29829, 4-step final step (quarter+half+IRQ), wrap point in 4-step mode
STEP5, 37281, 5-step final step (quarter+half), wrap point in 5-step mode
WR_DELAY, 3, CPU cycles from $4017 write to sequencer reset (range 1..7)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
cpu_ce  in  1  one-clk enable, one per CPU cycle
wr_en  in  1  $4017 write strobe, sampled every clk
wr_data  in  8  [7]=mode (0 = 4-step, 1 = 5-step), [6]=IRQ inhibit
status_rd  in  1  $4015 read strobe; clears the frame IRQ
qframe  out  1  quarter-frame strobe, 1 clk wide
hframe  out  1  half-frame strobe, 1 clk wide
irq  out  1  frame IRQ level
mode  out  1  active sequencer mode

Behaviour:
- Reset, when rst_n=0 at a clk edge:
  - cyc=0, mode=0, inhibit=0, irq=0.
  - qframe=hframe=0, state=RUN, delay=0.
  - Reset takes priority over all other inputs.
- Event timing:
  - All qframe/hframe pulses are registered.
  - A pulse asserts in the clk after the cpu_ce edge on which cyc matched a step, and lasts exactly 1 clk.
- Counter:
  - On cpu_ce, cyc increments by 1.
  - In mode 0, cyc at STEP4 wraps to 0 (period STEP4+1).
  - In mode 1, cyc at STEP5 wraps to 0 (period STEP5+1).
  - When cpu_ce=0, nothing advances.
- Mode 0 events: STEP1 gives q; STEP2 gives q+h; STEP3 gives q; STEP4 gives q+h, and sets irq if inhibit=0.
- Mode 1 events: STEP1 gives q; STEP2 gives q+h; STEP3 gives q; STEP4 gives nothing; STEP5 gives q+h. Mode 1 never sets irq.
- Write handling, FSM states RUN and PEND:
  - wr_en in any state latches pend_mode=wr_data[7] and inhibit=wr_data[6] immediately.
  - If wr_data[6]=1, irq clears the next clk.
  - Then delay=WR_DELAY and the state goes to PEND.
  - In PEND, the counter keeps running in the old mode and step events still fire. delay decrements on each cpu_ce.
  - In PEND, on the cpu_ce where delay==1: cyc<=0, mode<=pend_mode, state goes to RUN. If pend_mode=1, q+h fire on that same edge; this overrides any step event coinciding on that edge.
  - A write while in PEND re-latches the data and restarts delay at WR_DELAY; the earlier write is lost.
- IRQ:
  - Level output, held until status_rd, or a write with bit6=1, or reset.
  - If status_rd and an IRQ set event occur in the same clk, the set wins and irq stays 1.
- Counter width: cyc never exceeds STEP5; no overflow handling is needed. CNT_W must hold STEP5.

Optional Feature:
FRAME_IRQ_EN.
- Defined: IRQ logic as above.
- Undefined: irq is tied to 0. wr_data[6] and status_rd are ignored (no logic generated). Sequencing and strobes are unchanged.

Decomposition:
- Package apu_pkg holds:
  - STEP* default constants.
  - Mode encoding constants MODE_4STEP=0 and MODE_5STEP=1.
  - FSM state encoding RUN/PEND.
- One sub-module, apu_wr_delay: it loads WR_DELAY on a write, counts down on cpu_ce, and emits a single-clk apply pulse.
- Counter, step decode and IRQ live in the top.

Test Plan:
- Reset, then cpu_ce every clk, mode 0 -> q pulses at cyc 7457, 14913, 22371, 29829; h at 14913 and 29829; irq=1 after 29829; cyc back to 0 after 29829.
- Write 0x80 -> after 3 cpu_ce, immediate q+h, mode=1. Next pulses at 7457, 14913 (q+h), 22371, 37281 (q+h); irq stays 0 at 29829.
- irq=1, then status_rd -> irq=0 the next clk. Also irq=1, then write 0x40 -> irq=0; a subsequent STEP4 does not set irq.
- Write 0x00 at cyc 100, write 0x80 one cpu_ce later -> only the second applies. Reset happens 3 cpu_ce after the second write, with an immediate q+h.
- status_rd asserted in the same clk as the STEP4 irq set -> irq=1.
- cpu_ce held 0 for 50 clks mid-frame -> cyc, delay and outputs frozen. rst_n=0 during PEND -> mode=0, state RUN, no pending apply.
